// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies the synchronised lock,
// supervises lock loss and lock timeout, and releases the downstream system reset.
module pll_rst_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int RELEASE_CYCLES = 64,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       req_restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    // Loss counter saturates rather than wrapping so software sees "many".
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       retry_nxt_s;
    logic [7:0]       loss_nxt_s;
    logic             lock_meta_r;
    logic             lock_sync_r;
    logic             pll_rst_nxt_s;
    logic             sys_rst_nxt_s;
    logic             pll_ready_nxt_s;
    logic             fail_nxt_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state, counter and status-counter logic; lock drop beats terminal counts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_cnt;
        loss_nxt_s  = loss_cnt;
        if (req_restart) begin
            state_nxt_s = S_RESET_PLL;
            cnt_nxt_s   = CNT_ZERO;
            retry_nxt_s = 2'd0;
        end else begin
            case (state_r)
                S_RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt_s = S_WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_nxt_s = S_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt_s = S_FAIL;
                        end else begin
                            retry_nxt_s = retry_cnt + 2'd1;
                            state_nxt_s = S_RESET_PLL;
                            cnt_nxt_s   = CNT_ZERO;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    // A drop before qualification is a glitch: requalify without penalty.
                    if (!lock_sync_r) begin
                        state_nxt_s = S_WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = S_RELEASE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (!lock_sync_r) begin
                        loss_nxt_s  = sat_inc8(loss_cnt);
                        state_nxt_s = S_RESET_PLL;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == RELEASE_LAST) begin
                        state_nxt_s = S_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                        retry_nxt_s = 2'd0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_sync_r) begin
                        loss_nxt_s  = sat_inc8(loss_cnt);
                        state_nxt_s = S_RESET_PLL;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                S_FAIL: begin
                    state_nxt_s = S_FAIL;
                end
                default: begin
                    state_nxt_s = S_RESET_PLL;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        pll_rst_nxt_s   = 1'b1;
        sys_rst_nxt_s   = 1'b1;
        pll_ready_nxt_s = 1'b0;
        fail_nxt_s      = 1'b0;
        case (state_nxt_s)
            S_RESET_PLL: begin
                pll_rst_nxt_s = 1'b1;
            end
            S_WAIT_LOCK, S_STABLE: begin
                pll_rst_nxt_s = 1'b0;
            end
            S_RELEASE: begin
                pll_rst_nxt_s   = 1'b0;
                pll_ready_nxt_s = 1'b1;
            end
            S_RUN: begin
                pll_rst_nxt_s   = 1'b0;
                sys_rst_nxt_s   = 1'b0;
                pll_ready_nxt_s = 1'b1;
            end
            S_FAIL: begin
                pll_rst_nxt_s = 1'b1;
                fail_nxt_s    = 1'b1;
            end
            default: begin
                pll_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_RESET_PLL;
            cnt_r     <= CNT_ZERO;
            retry_cnt <= 2'd0;
            loss_cnt  <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            pll_ready <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            retry_cnt <= retry_nxt_s;
            loss_cnt  <= loss_nxt_s;
            pll_rst   <= pll_rst_nxt_s;
            sys_rst   <= sys_rst_nxt_s;
            pll_ready <= pll_ready_nxt_s;
            fail      <= fail_nxt_s;
        end
    end

endmodule
